// File: rtl/decode_pkg.sv
// decode_pkg: shared widths and payload layouts for the decode input stage.
//   - Lane payload: pc, fid, instruction, predictor pattern/taken/hit and
//     predicted target. One lane_payload_t per fetch lane (108 bits).
//   - Writeback payload: wb_en plus the wb_rest_t fields. wb_en is kept
//     separate from the rest because it is the only reset writeback bit.
package decode_pkg;

  localparam int FID_W      = 8;
  localparam int ROB_W      = 4;
  localparam int BP_PAT_W   = 2;
  localparam int CMTDELAY_W = 4;

  localparam int LANE_PAYLOAD_W = 32 + FID_W + 32 + BP_PAT_W + 1 + 1 + 32;

  typedef struct packed {
    logic [31:0]         pc;
    logic [FID_W-1:0]    fid;
    logic [31:0]         data;
    logic [BP_PAT_W-1:0] bp_pattern;
    logic                bp_taken;
    logic                bp_hit;
    logic [31:0]         bp_target;
  } lane_payload_t;

  localparam int WB_REST_W = 3 + ROB_W + CMTDELAY_W + FID_W + 32 + 32 + BP_PAT_W;
  localparam int WB_PAYLOAD_W = 1 + WB_REST_W;

  typedef struct packed {
    logic                  lsmiss;
    logic                  bco_valid;
    logic                  bco_taken;
    logic [ROB_W-1:0]      dst_rob;
    logic [CMTDELAY_W-1:0] cmtdelay;
    logic [FID_W-1:0]      fid;
    logic [31:0]           value;
    logic [31:0]           bco_target;
    logic [BP_PAT_W-1:0]   bco_pattern;
  } wb_rest_t;

endpackage

// File: rtl/pipe_skid_buf.sv
// pipe_skid_buf: generic 2-entry (main + skid) valid/ready register stage.
// Ports:
//   clk, resetn   clock, synchronous active-low reset (valids only)
//   flush         clears both entries next cycle; a push this cycle is lost
//   in_valid/in_ready/in_data     upstream handshake
//   out_valid/out_ready/out_data  downstream handshake
// in_ready is taken straight from the skid valid flop, so there is no
// combinational path from out_ready to in_ready.
module pipe_skid_buf #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
);

  logic              main_vld_q, main_vld_d;
  logic              skid_vld_q, skid_vld_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic              push, pop;

  assign in_ready  = ~skid_vld_q;
  assign out_valid = main_vld_q;
  assign out_data  = main_data_q;

  assign push = in_valid & in_ready;
  assign pop  = main_vld_q & out_ready;

  always_comb begin
    main_vld_d  = main_vld_q;
    skid_vld_d  = skid_vld_q;
    main_data_d = main_data_q;
    skid_data_d = skid_data_q;
    if (skid_vld_q) begin
      // in_ready is low, so no push can arrive; only drain skid into main.
      if (pop) begin
        main_data_d = skid_data_q;
        skid_vld_d  = 1'b0;
      end
    end else if (!main_vld_q || pop) begin
      main_vld_d = push;
      if (push) main_data_d = in_data;
    end else if (push) begin
      skid_vld_d  = 1'b1;
      skid_data_d = in_data;
    end
    if (flush) begin
      main_vld_d = 1'b0;
      skid_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      main_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
    end else begin
      main_vld_q <= main_vld_d;
      skid_vld_q <= skid_vld_d;
    end
  end

  always_ff @(posedge clk) begin
    main_data_q <= main_data_d;
    skid_data_q <= skid_data_d;
  end

endmodule

// File: rtl/decode_pipe_regs.sv
// decode_pipe_regs: fetch-to-decode input register stage.
// Ports:
//   clk, resetn          clock, synchronous active-low reset
//   snoop_hit            starts a SNOOP_HOLD-cycle flush window
//   bco_valid            branch-commit override, flushes this cycle
//   i_* / i_ready        LANES-wide fetch bundle in (valid is a lane mask)
//   o_* / o_ready        registered bundle out to DECODE
//   i_wb_* / o_wb_*      WB_CH writeback channels, registered (WB_DFF=1)
//                        or passed through (WB_DFF=0); never flushed
module decode_pipe_regs
  import decode_pkg::*;
#(
  parameter int LANES      = 2,
  parameter int WB_CH      = 2,
  parameter int SNOOP_HOLD = 2,
  parameter int WB_DFF     = 1
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     snoop_hit,
  input  logic                     bco_valid,
  input  logic [LANES-1:0]         i_valid,
  output logic                     i_ready,
  input  logic [32*LANES-1:0]      i_pc,
  input  logic [32*LANES-1:0]      i_data,
  input  logic [32*LANES-1:0]      i_bp_target,
  input  logic [8*LANES-1:0]       i_fid,
  input  logic [2*LANES-1:0]       i_bp_pattern,
  input  logic [LANES-1:0]         i_bp_taken,
  input  logic [LANES-1:0]         i_bp_hit,
  output logic [LANES-1:0]         o_valid,
  input  logic                     o_ready,
  output logic [32*LANES-1:0]      o_pc,
  output logic [32*LANES-1:0]      o_data,
  output logic [32*LANES-1:0]      o_bp_target,
  output logic [8*LANES-1:0]       o_fid,
  output logic [2*LANES-1:0]       o_bp_pattern,
  output logic [LANES-1:0]         o_bp_taken,
  output logic [LANES-1:0]         o_bp_hit,
  input  logic [WB_CH-1:0]         i_wb_en,
  input  logic [WB_CH-1:0]         i_wb_lsmiss,
  input  logic [WB_CH-1:0]         i_wb_bco_valid,
  input  logic [WB_CH-1:0]         i_wb_bco_taken,
  input  logic [4*WB_CH-1:0]       i_wb_dst_rob,
  input  logic [4*WB_CH-1:0]       i_wb_cmtdelay,
  input  logic [8*WB_CH-1:0]       i_wb_fid,
  input  logic [32*WB_CH-1:0]      i_wb_value,
  input  logic [32*WB_CH-1:0]      i_wb_bco_target,
  input  logic [2*WB_CH-1:0]       i_wb_bco_pattern,
  output logic [WB_CH-1:0]         o_wb_en,
  output logic [WB_CH-1:0]         o_wb_lsmiss,
  output logic [WB_CH-1:0]         o_wb_bco_valid,
  output logic [WB_CH-1:0]         o_wb_bco_taken,
  output logic [4*WB_CH-1:0]       o_wb_dst_rob,
  output logic [4*WB_CH-1:0]       o_wb_cmtdelay,
  output logic [8*WB_CH-1:0]       o_wb_fid,
  output logic [32*WB_CH-1:0]      o_wb_value,
  output logic [32*WB_CH-1:0]      o_wb_bco_target,
  output logic [2*WB_CH-1:0]       o_wb_bco_pattern
);

  // Lane mask rides in the buffer above the lane payloads.
  localparam int BUF_W = LANES * LANE_PAYLOAD_W + LANES;
  localparam int CNT_W = (SNOOP_HOLD > 1) ? $clog2(SNOOP_HOLD) : 1;

  logic [CNT_W-1:0] snoop_cnt_q, snoop_cnt_d;
  logic             flush;

  // Counter holds the remaining flush cycles after the snoop_hit cycle.
  always_comb begin
    snoop_cnt_d = snoop_cnt_q;
    if (snoop_hit)                snoop_cnt_d = CNT_W'(SNOOP_HOLD - 1);
    else if (snoop_cnt_q != '0)   snoop_cnt_d = snoop_cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!resetn) snoop_cnt_q <= '0;
    else         snoop_cnt_q <= snoop_cnt_d;
  end

  assign flush = snoop_hit | (snoop_cnt_q != '0) | bco_valid;

  lane_payload_t [LANES-1:0] in_lanes, out_lanes;
  logic [LANES-1:0]          out_mask;
  logic [BUF_W-1:0]          buf_in, buf_out;
  logic                      main_valid;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign in_lanes[l] = '{pc:         i_pc[32*l +: 32],
                           fid:        i_fid[8*l +: 8],
                           data:       i_data[32*l +: 32],
                           bp_pattern: i_bp_pattern[2*l +: 2],
                           bp_taken:   i_bp_taken[l],
                           bp_hit:     i_bp_hit[l],
                           bp_target:  i_bp_target[32*l +: 32]};
    assign o_pc[32*l +: 32]        = out_lanes[l].pc;
    assign o_fid[8*l +: 8]         = out_lanes[l].fid;
    assign o_data[32*l +: 32]      = out_lanes[l].data;
    assign o_bp_pattern[2*l +: 2]  = out_lanes[l].bp_pattern;
    assign o_bp_taken[l]           = out_lanes[l].bp_taken;
    assign o_bp_hit[l]             = out_lanes[l].bp_hit;
    assign o_bp_target[32*l +: 32] = out_lanes[l].bp_target;
  end

  assign buf_in                = {i_valid, in_lanes};
  assign {out_mask, out_lanes} = buf_out;
  assign o_valid               = main_valid ? out_mask : '0;

  pipe_skid_buf #(.DATA_W(BUF_W)) u_skid (
    .clk       (clk),
    .resetn    (resetn),
    .flush     (flush),
    .in_valid  (|i_valid),
    .in_ready  (i_ready),
    .in_data   (buf_in),
    .out_valid (main_valid),
    .out_ready (o_ready),
    .out_data  (buf_out)
  );

  wb_rest_t [WB_CH-1:0] wb_rest_in, wb_rest_out;
  logic     [WB_CH-1:0] wb_en_out;

  for (genvar c = 0; c < WB_CH; c++) begin : g_wb
    assign wb_rest_in[c] = '{lsmiss:      i_wb_lsmiss[c],
                             bco_valid:   i_wb_bco_valid[c],
                             bco_taken:   i_wb_bco_taken[c],
                             dst_rob:     i_wb_dst_rob[4*c +: 4],
                             cmtdelay:    i_wb_cmtdelay[4*c +: 4],
                             fid:         i_wb_fid[8*c +: 8],
                             value:       i_wb_value[32*c +: 32],
                             bco_target:  i_wb_bco_target[32*c +: 32],
                             bco_pattern: i_wb_bco_pattern[2*c +: 2]};

    if (WB_DFF != 0) begin : g_reg
      logic [WB_PAYLOAD_W-1:0] wb_d, wb_q;
      always_comb wb_d = {i_wb_en[c], wb_rest_in[c]};
      // Only the enable bit is reset; the payload bits are don't-care while en=0.
      always_ff @(posedge clk) begin
        wb_q[WB_REST_W-1:0] <= wb_d[WB_REST_W-1:0];
        if (!resetn) wb_q[WB_PAYLOAD_W-1] <= 1'b0;
        else         wb_q[WB_PAYLOAD_W-1] <= wb_d[WB_PAYLOAD_W-1];
      end
      assign wb_en_out[c]   = wb_q[WB_PAYLOAD_W-1];
      assign wb_rest_out[c] = wb_q[WB_REST_W-1:0];
    end else begin : g_comb
      assign wb_en_out[c]   = i_wb_en[c];
      assign wb_rest_out[c] = wb_rest_in[c];
    end

    assign o_wb_en[c]                = wb_en_out[c];
    assign o_wb_lsmiss[c]            = wb_rest_out[c].lsmiss;
    assign o_wb_bco_valid[c]         = wb_rest_out[c].bco_valid;
    assign o_wb_bco_taken[c]         = wb_rest_out[c].bco_taken;
    assign o_wb_dst_rob[4*c +: 4]    = wb_rest_out[c].dst_rob;
    assign o_wb_cmtdelay[4*c +: 4]   = wb_rest_out[c].cmtdelay;
    assign o_wb_fid[8*c +: 8]        = wb_rest_out[c].fid;
    assign o_wb_value[32*c +: 32]    = wb_rest_out[c].value;
    assign o_wb_bco_target[32*c +: 32] = wb_rest_out[c].bco_target;
    assign o_wb_bco_pattern[2*c +: 2]  = wb_rest_out[c].bco_pattern;
  end

endmodule

// File: tb/tb_decode_pipe_regs.sv
// tb_decode_pipe_regs: directed bench for decode_pipe_regs. dut1 uses the
// default parameters; dut2 (SNOOP_HOLD=3, WB_DFF=0) shares all inputs.
module tb_decode_pipe_regs;

  logic clk;
  logic resetn, snoop_hit, bco_valid, o_ready;
  logic [1:0]  i_valid, i_bp_taken, i_bp_hit;
  logic [63:0] i_pc, i_data, i_bp_target;
  logic [15:0] i_fid;
  logic [3:0]  i_bp_pattern;
  logic [1:0]  i_wb_en, i_wb_lsmiss, i_wb_bco_valid, i_wb_bco_taken;
  logic [7:0]  i_wb_dst_rob, i_wb_cmtdelay;
  logic [15:0] i_wb_fid;
  logic [63:0] i_wb_value, i_wb_bco_target;
  logic [3:0]  i_wb_bco_pattern;

  logic        i_ready, i_ready2;
  logic [1:0]  o_valid, o_bp_taken, o_bp_hit, o_valid2, o_bp_taken2, o_bp_hit2;
  logic [63:0] o_pc, o_data, o_bp_target, o_pc2, o_data2, o_bp_target2;
  logic [15:0] o_fid, o_fid2;
  logic [3:0]  o_bp_pattern, o_bp_pattern2;
  logic [1:0]  o_wb_en, o_wb_lsmiss, o_wb_bco_valid, o_wb_bco_taken;
  logic [1:0]  o_wb_en2, o_wb_lsmiss2, o_wb_bco_valid2, o_wb_bco_taken2;
  logic [7:0]  o_wb_dst_rob, o_wb_cmtdelay, o_wb_dst_rob2, o_wb_cmtdelay2;
  logic [15:0] o_wb_fid, o_wb_fid2;
  logic [63:0] o_wb_value, o_wb_bco_target, o_wb_value2, o_wb_bco_target2;
  logic [3:0]  o_wb_bco_pattern, o_wb_bco_pattern2;

  decode_pipe_regs #(.LANES(2), .WB_CH(2), .SNOOP_HOLD(2), .WB_DFF(1)) dut1 (
    .clk(clk), .resetn(resetn), .snoop_hit(snoop_hit), .bco_valid(bco_valid),
    .i_valid(i_valid), .i_ready(i_ready), .i_pc(i_pc), .i_data(i_data),
    .i_bp_target(i_bp_target), .i_fid(i_fid), .i_bp_pattern(i_bp_pattern),
    .i_bp_taken(i_bp_taken), .i_bp_hit(i_bp_hit), .o_valid(o_valid), .o_ready(o_ready),
    .o_pc(o_pc), .o_data(o_data), .o_bp_target(o_bp_target), .o_fid(o_fid),
    .o_bp_pattern(o_bp_pattern), .o_bp_taken(o_bp_taken), .o_bp_hit(o_bp_hit),
    .i_wb_en(i_wb_en), .i_wb_lsmiss(i_wb_lsmiss), .i_wb_bco_valid(i_wb_bco_valid),
    .i_wb_bco_taken(i_wb_bco_taken), .i_wb_dst_rob(i_wb_dst_rob), .i_wb_cmtdelay(i_wb_cmtdelay),
    .i_wb_fid(i_wb_fid), .i_wb_value(i_wb_value), .i_wb_bco_target(i_wb_bco_target),
    .i_wb_bco_pattern(i_wb_bco_pattern), .o_wb_en(o_wb_en), .o_wb_lsmiss(o_wb_lsmiss),
    .o_wb_bco_valid(o_wb_bco_valid), .o_wb_bco_taken(o_wb_bco_taken),
    .o_wb_dst_rob(o_wb_dst_rob), .o_wb_cmtdelay(o_wb_cmtdelay), .o_wb_fid(o_wb_fid),
    .o_wb_value(o_wb_value), .o_wb_bco_target(o_wb_bco_target), .o_wb_bco_pattern(o_wb_bco_pattern)
  );

  decode_pipe_regs #(.LANES(2), .WB_CH(2), .SNOOP_HOLD(3), .WB_DFF(0)) dut2 (
    .clk(clk), .resetn(resetn), .snoop_hit(snoop_hit), .bco_valid(bco_valid),
    .i_valid(i_valid), .i_ready(i_ready2), .i_pc(i_pc), .i_data(i_data),
    .i_bp_target(i_bp_target), .i_fid(i_fid), .i_bp_pattern(i_bp_pattern),
    .i_bp_taken(i_bp_taken), .i_bp_hit(i_bp_hit), .o_valid(o_valid2), .o_ready(o_ready),
    .o_pc(o_pc2), .o_data(o_data2), .o_bp_target(o_bp_target2), .o_fid(o_fid2),
    .o_bp_pattern(o_bp_pattern2), .o_bp_taken(o_bp_taken2), .o_bp_hit(o_bp_hit2),
    .i_wb_en(i_wb_en), .i_wb_lsmiss(i_wb_lsmiss), .i_wb_bco_valid(i_wb_bco_valid),
    .i_wb_bco_taken(i_wb_bco_taken), .i_wb_dst_rob(i_wb_dst_rob), .i_wb_cmtdelay(i_wb_cmtdelay),
    .i_wb_fid(i_wb_fid), .i_wb_value(i_wb_value), .i_wb_bco_target(i_wb_bco_target),
    .i_wb_bco_pattern(i_wb_bco_pattern), .o_wb_en(o_wb_en2), .o_wb_lsmiss(o_wb_lsmiss2),
    .o_wb_bco_valid(o_wb_bco_valid2), .o_wb_bco_taken(o_wb_bco_taken2),
    .o_wb_dst_rob(o_wb_dst_rob2), .o_wb_cmtdelay(o_wb_cmtdelay2), .o_wb_fid(o_wb_fid2),
    .o_wb_value(o_wb_value2), .o_wb_bco_target(o_wb_bco_target2), .o_wb_bco_pattern(o_wb_bco_pattern2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  iv;
    logic [31:0] pc;
    logic        ordy, snoop, bco;
    logic [1:0]  ov;
    logic [31:0] epc;
    logic        ir;
    logic [1:0]  ov2;
  } vec_t;

  vec_t vecs[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic add(input logic [1:0] iv, input logic [31:0] pc, input logic ordy,
                     input logic snoop, input logic bco, input logic [1:0] ov,
                     input logic [31:0] epc, input logic ir, input logic [1:0] ov2);
    vec_t v;
    v.iv = iv; v.pc = pc; v.ordy = ordy; v.snoop = snoop; v.bco = bco;
    v.ov = ov; v.epc = epc; v.ir = ir; v.ov2 = ov2;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Lane 1 pc is lane 0 pc + 4; other lane fields are derived from pc.
  task automatic drive_bundle(input logic [1:0] iv, input logic [31:0] pc);
    logic [31:0] pc1;
    pc1          = pc + 32'd4;
    i_valid      = iv;
    i_pc         = {pc1, pc};
    i_data       = ~{pc1, pc};
    i_bp_target  = {pc1 + 32'h40, pc + 32'h40};
    i_fid        = {pc1[7:0], pc[7:0]};
    i_bp_pattern = 4'b1010;
    i_bp_taken   = iv;
    i_bp_hit     = iv;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    resetn = 1'b0; snoop_hit = 1'b0; bco_valid = 1'b0; o_ready = 1'b0;
    drive_bundle(2'b00, 32'h0);
    i_wb_en = '0; i_wb_lsmiss = '0; i_wb_bco_valid = '0; i_wb_bco_taken = '0;
    i_wb_dst_rob = '0; i_wb_cmtdelay = '0; i_wb_fid = '0; i_wb_value = '0;
    i_wb_bco_target = '0; i_wb_bco_pattern = '0;
    step();
    step();
    chk("reset o_valid", o_valid, 2'b00);
    chk("reset i_ready", i_ready, 1'b1);
    chk("reset o_wb_en", o_wb_en, 2'b00);
    chk("reset o_valid2", o_valid2, 2'b00);
    resetn = 1'b1;

    //   iv     pc       ordy snp  bco   ov     epc      ir   ov2
    add(2'b11, 32'h100, 1, 0, 0, 2'b11, 32'h100, 1, 2'b11);  // streaming
    add(2'b11, 32'h108, 1, 0, 0, 2'b11, 32'h108, 1, 2'b11);
    add(2'b00, 32'h0,   1, 0, 0, 2'b00, 32'h0,   1, 2'b00);
    add(2'b11, 32'h200, 0, 0, 0, 2'b11, 32'h200, 1, 2'b11);  // A, stalled
    add(2'b01, 32'h300, 0, 0, 0, 2'b11, 32'h200, 0, 2'b11);  // B -> skid
    add(2'b11, 32'h400, 0, 0, 0, 2'b11, 32'h200, 0, 2'b11);  // C refused
    add(2'b11, 32'h400, 1, 0, 0, 2'b01, 32'h300, 1, 2'b01);  // pop A, B to main
    add(2'b11, 32'h400, 1, 0, 0, 2'b11, 32'h400, 1, 2'b11);  // pop B, push C
    add(2'b00, 32'h0,   1, 0, 0, 2'b00, 32'h0,   1, 2'b00);
    add(2'b11, 32'h500, 0, 0, 0, 2'b11, 32'h500, 1, 2'b11);  // fill both
    add(2'b11, 32'h600, 0, 0, 0, 2'b11, 32'h500, 0, 2'b11);
    add(2'b11, 32'h700, 0, 1, 0, 2'b00, 32'h0,   1, 2'b00);  // snoop_hit
    add(2'b11, 32'h800, 1, 0, 0, 2'b00, 32'h0,   1, 2'b00);  // hold, dropped
    add(2'b11, 32'h900, 1, 0, 0, 2'b11, 32'h900, 1, 2'b00);  // dut2 still held
    add(2'b00, 32'h0,   1, 0, 0, 2'b00, 32'h0,   1, 2'b00);
    add(2'b11, 32'hA00, 1, 0, 0, 2'b11, 32'hA00, 1, 2'b11);
    add(2'b00, 32'h0,   1, 0, 0, 2'b00, 32'h0,   1, 2'b00);
    add(2'b11, 32'hB00, 0, 0, 0, 2'b11, 32'hB00, 1, 2'b11);
    add(2'b11, 32'hC00, 1, 0, 1, 2'b00, 32'h0,   1, 2'b00);  // bco + push + pop
    add(2'b00, 32'h0,   1, 0, 0, 2'b00, 32'h0,   1, 2'b00);

    for (int i = 0; i < vecs.size(); i++) begin
      drive_bundle(vecs[i].iv, vecs[i].pc);
      o_ready   = vecs[i].ordy;
      snoop_hit = vecs[i].snoop;
      bco_valid = vecs[i].bco;
      step();
      chk($sformatf("row%0d o_valid", i), o_valid, vecs[i].ov);
      chk($sformatf("row%0d i_ready", i), i_ready, vecs[i].ir);
      chk($sformatf("row%0d o_valid2", i), o_valid2, vecs[i].ov2);
      if (vecs[i].ov != 2'b00) begin
        chk($sformatf("row%0d o_pc", i), o_pc, {vecs[i].epc + 32'd4, vecs[i].epc});
        chk($sformatf("row%0d o_data", i), o_data, ~{vecs[i].epc + 32'd4, vecs[i].epc});
        chk($sformatf("row%0d o_bp_target0", i), o_bp_target[31:0], vecs[i].epc + 32'h40);
        chk($sformatf("row%0d o_bp_taken", i), o_bp_taken, vecs[i].ov);
      end
    end
    snoop_hit = 1'b0; bco_valid = 1'b0;

    // Writeback during a snoop flush with DECODE stalled.
    drive_bundle(2'b00, 32'h0);
    o_ready = 1'b0; snoop_hit = 1'b1;
    i_wb_en = 2'b11; i_wb_dst_rob = {4'd9, 4'd5}; i_wb_cmtdelay = {4'd3, 4'd7};
    i_wb_fid = {8'h22, 8'h11}; i_wb_value = {32'h12345678, 32'hDEADBEEF};
    i_wb_bco_target = {32'h0000_2000, 32'h0000_1000}; i_wb_lsmiss = 2'b10;
    #1;
    chk("wb comb en2", o_wb_en2, 2'b11);
    chk("wb comb rob2", o_wb_dst_rob2, {4'd9, 4'd5});
    chk("wb comb value2", o_wb_value2, {32'h12345678, 32'hDEADBEEF});
    chk("wb reg en before edge", o_wb_en, 2'b00);
    step();
    chk("wb reg en", o_wb_en, 2'b11);
    chk("wb reg rob", o_wb_dst_rob, {4'd9, 4'd5});
    chk("wb reg value", o_wb_value, {32'h12345678, 32'hDEADBEEF});
    chk("wb reg fid", o_wb_fid, {8'h22, 8'h11});
    chk("wb reg cmtdelay", o_wb_cmtdelay, {4'd3, 4'd7});
    chk("wb reg lsmiss", o_wb_lsmiss, 2'b10);
    chk("wb flush o_valid", o_valid, 2'b00);
    snoop_hit = 1'b0;
    i_wb_en = 2'b01; i_wb_value = {32'hCAFEF00D, 32'hDEADBEEF};
    step();
    chk("wb reg en2", o_wb_en, 2'b01);
    chk("wb reg value2", o_wb_value, {32'hCAFEF00D, 32'hDEADBEEF});
    i_wb_en = 2'b00;
    step();
    step();

    // Reset with both entries full and a snoop arriving in the reset cycle.
    i_wb_en = 2'b11;
    drive_bundle(2'b11, 32'hD00);
    step();
    drive_bundle(2'b11, 32'hE00);
    step();
    chk("full i_ready", i_ready, 1'b0);
    chk("full o_valid", o_valid, 2'b11);
    chk("full o_wb_en", o_wb_en, 2'b11);
    resetn = 1'b0; snoop_hit = 1'b1;
    drive_bundle(2'b00, 32'h0);
    step();
    chk("midreset o_valid", o_valid, 2'b00);
    chk("midreset o_wb_en", o_wb_en, 2'b00);
    chk("midreset i_ready", i_ready, 1'b1);
    chk("midreset o_valid2", o_valid2, 2'b00);
    resetn = 1'b1; snoop_hit = 1'b0; i_wb_en = 2'b00; o_ready = 1'b1;
    drive_bundle(2'b10, 32'hF00);
    step();
    chk("post-reset o_valid", o_valid, 2'b10);
    chk("post-reset o_pc", o_pc, {32'hF04, 32'hF00});
    chk("post-reset o_valid2", o_valid2, 2'b10);
    drive_bundle(2'b00, 32'h0);
    step();
    chk("post-reset drain", o_valid, 2'b00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/decode_pipe_regs.md
Name: decode_pipe_regs

Overview:
Parametrised successor to the single-lane decode input register stage. Registers a LANES-wide fetch bundle into DECODE behind a valid/ready handshake with a 2-entry skid buffer, so DECODE back-pressure never drops a bundle. Flushes on snoop refresh (programmable hold) and on branch-commit override. Also carries WB_CH independent writeback channels with optional 1-cycle retiming.

Parameters:
LANES, 2, fetch lanes per bundle (1..4)
WB_CH, 2, writeback channels (1..4)
SNOOP_HOLD, 2, flush cycles per snoop_hit (>=1)
WB_DFF, 1, 1 = register writeback channels; 0 = combinational pass-through

Ports:
clk  in  1  clock
resetn  in  1  synchronous active-low reset
snoop_hit  in  1  snoop refresh request
bco_valid  in  1  branch-commit override flush
i_valid  in  LANES  per-lane valid; bundle present when any bit set
i_ready  out  1  stage can accept a bundle
i_pc / i_data / i_bp_target  in  32*LANES  per-lane pc, instruction, predicted target
i_fid  in  8*LANES  fetch id
i_bp_pattern  in  2*LANES  predictor pattern
i_bp_taken / i_bp_hit  in  LANES  predictor flags
o_valid  out  LANES  registered lane valids
o_ready  in  1  DECODE accepts the bundle
o_pc, o_data, o_bp_target, o_fid, o_bp_pattern, o_bp_taken, o_bp_hit  out  same widths as inputs
i_wb_en / i_wb_lsmiss / i_wb_bco_valid / i_wb_bco_taken  in  WB_CH  writeback flags
i_wb_dst_rob / i_wb_cmtdelay  in  4*WB_CH  ROB index, commit delay
i_wb_fid  in  8*WB_CH  fetch id
i_wb_value / i_wb_bco_target  in  32*WB_CH  result, BCO target
i_wb_bco_pattern  in  2*WB_CH  BCO pattern
o_wb_*  out  mirror of every i_wb_* field

Behaviour:
- Reset (resetn=0 at a clk edge): main and skid valids = 0; o_valid = 0; i_ready = 1 from the next cycle; snoop counter = 0; o_wb_en = 0. Payload registers are not reset.
- Flush = snoop_hit | (snoop_cnt != 0) | bco_valid.
- Snoop counter: when snoop_hit is high, load SNOOP_HOLD-1. Otherwise, if nonzero, decrement. This gives exactly SNOOP_HOLD flush cycles per isolated hit. A re-hit reloads the counter.
- Push when (|i_valid) & i_ready. Pop when (|o_valid) & o_ready.
- Latency: 1 cycle from push to o_valid when the main register is empty, or is being popped in the same cycle.
- Skid buffer:
  - Push while main is full and not popping: bundle goes to the skid register.
  - Pop with skid full: skid moves to main, and the skid register clears.
  - i_ready = ~skid_valid, registered. Combinational paths from o_ready are forbidden.
- Flush cycle:
  - Next-state main and skid valids = 0.
  - Any push in that cycle is discarded.
  - Flush has priority over push and pop.
  - i_ready = 1 in the cycle after the flush.
- Lane valids are held as a mask and move with the bundle. Lanes never shift or compact.
- Order: bundles leave in push order. No bundle is duplicated or lost except by flush.
- Writeback, WB_DFF=1:
  - Every o_wb_* equals the matching i_wb_* one cycle later.
  - Only wb_en is reset.
  - Writeback is unaffected by flush and by back-pressure.
- Writeback, WB_DFF=0: o_wb_* = i_wb_* combinationally.
- Reset mid-operation discards both buffered bundles and the flush state.

Decomposition:
- Shared package decode_pkg holds:
  - FID_W=8, ROB_W=4, BP_PAT_W=2, CMTDELAY_W=4.
  - Lane payload width LANE_PAYLOAD_W=108 (pc 32, fid 8, data 32, pattern 2, taken 1, hit 1, target 32).
  - Writeback payload width.
- One sub-module, pipe_skid_buf: a generic 2-entry skid buffer parameterised on payload width, with a flush input.
- The top level packs lanes into the payload, holds the snoop counter, and generates the WB_CH writeback registers.

Test Plan:
- Streaming, o_ready=1, LANES=2, i_valid=2'b11 with pc 0x100, 0x104, then 0x108, 0x10C: o_valid=2'b11 one cycle later, same pc order; i_ready stays 1.
- Back-pressure: o_ready=0 after bundle A; push B, then C is offered. B goes to the skid register, i_ready=0 next cycle, C is not taken. Raising o_ready pops A, then B, then C, with no loss.
- Snoop, SNOOP_HOLD=2: snoop_hit for 1 cycle with both entries full. o_valid=0 for 2 cycles and pushes in those cycles are dropped. With SNOOP_HOLD=3 the drop window is 3 cycles.
- bco_valid together with a push and a pop: both entries cleared, pushed bundle absent, i_ready=1 the next cycle.
- Writeback: WB_CH=2, ch0 en=1 rob=5 value 0xDEADBEEF, ch1 en=1 rob=9. Both appear one cycle later even during a flush with o_ready=0. With WB_DFF=0 they appear the same cycle.
- resetn=0 with both entries full: after reset, o_valid=0, o_wb_en=0, i_ready=1.
